button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Per-button conditioning stage directly downstream of the 2-flop input synchronizer. It consumes the already-synchronized button level, debounces press and release, and emits single-cycle event pulses to the jukebox control FSM: press, release, long-press and auto-repeat. The control logic never sees raw bounce. One instance per front-panel button.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical samples required to accept a level change (>=1)
HOLD_CYCLES, 1000, cycles after press_pulse before long_pulse fires (>=1)
REPEAT_CYCLES, 250, period of repeat_pulse after long_pulse (>=1)
REPEAT_EN, 1, 1 = generate repeat_pulse while held; 0 = never

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
in_sync  in  1  synchronized button level, 1 = pressed
btn_level  out  1  debounced level
press_pulse  out  1  one-cycle pulse on accepted press
release_pulse  out  1  one-cycle pulse on accepted release
long_pulse  out  1  one-cycle pulse at long-press threshold
repeat_pulse  out  1  one-cycle auto-repeat pulse

Behaviour:
- Reset: clk is the system clock and rst is the asynchronous, active-low reset. While rst is low, state=IDLE, all counters=0, and all outputs=0. All outputs are registered.
- Counter widths: $clog2(max(param)+1) bits. The hold counter saturates and never wraps.
- States: IDLE, PRESS_DB, HELD, RELEASE_DB.
- IDLE:
  - in_sync=1 moves to PRESS_DB with db_cnt=1.
  - If DEBOUNCE_CYCLES=1, go straight to HELD and apply the press actions.
- PRESS_DB:
  - On each in_sync=1 sample, db_cnt increments.
  - Any in_sync=0 sample returns to IDLE with db_cnt=0, and no pulse is issued.
  - When the DEBOUNCE_CYCLES-th consecutive high sample is taken at edge t, then after edge t: state=HELD, btn_level=1, press_pulse=1 for exactly one cycle, hold_cnt=0.
  - Latency: first high sample at edge t0 gives press_pulse visible after edge t0+DEBOUNCE_CYCLES-1.
- HELD:
  - hold_cnt increments every cycle.
  - If press_pulse is in cycle P, long_pulse fires in cycle P+HOLD_CYCLES.
  - If REPEAT_EN=1, repeat_pulse fires in cycles P+HOLD_CYCLES+k*REPEAT_CYCLES, k>=1.
  - long_pulse and repeat_pulse never fire in the same cycle.
  - in_sync=0 moves to RELEASE_DB with db_cnt=1.
- RELEASE_DB:
  - hold_cnt and the repeat phase are frozen, and no long_pulse or repeat_pulse is issued.
  - btn_level stays 1.
  - Any in_sync=1 sample returns to HELD. Timing then resumes from the frozen count, and the frozen cycles are not counted.
  - When the DEBOUNCE_CYCLES-th consecutive low sample is taken, then after that edge: state=IDLE, btn_level=0, release_pulse=1 for one cycle, hold_cnt=0.
- Pulse exclusivity:
  - At most one of press_pulse and release_pulse is high in any cycle.
  - press_pulse is always followed by exactly one release_pulse before the next press_pulse.
- Reset mid-operation:
  - Pending pulses are dropped, and release_pulse is not emitted.
  - A button held through reset deassertion is treated as a new press. It needs a full DEBOUNCE_CYCLES before press_pulse.
- No combinational path from in_sync to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, REPEAT_EN=1.
1. Reset: assert rst low mid-stream with in_sync toggling -> all outputs 0 immediately (async); after release with in_sync=0, outputs stay 0.
2. Bounce rejection: in_sync high 3 cycles, low 1, high 3, low -> no pulses, btn_level stays 0.
3. Clean press 20 cycles: in_sync rises with first sample at edge 0 -> press_pulse and btn_level high after edge 3 (cycle P); long_pulse at P+10; repeat_pulse at P+13 and P+16. After in_sync falls, release_pulse fires 4 samples later; exactly one press_pulse and one release_pulse.
4. Release glitch: while HELD before the threshold, in_sync low 2 cycles then high -> no release_pulse; long_pulse is delayed by exactly 2 cycles (P+12); btn_level stays 1.
5. REPEAT_EN=0 with a 40-cycle hold -> exactly one long_pulse at P+10; no repeat_pulse.
6. Reset while held: rst low at P+5, released with in_sync=1 -> no release_pulse; a new press_pulse after 4 samples; hold timing restarts from the new P.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced button level with press/release/long/repeat pulses
// One instance per synchronized front-panel button; all outputs registered.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sync,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAXP   = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] db_cnt, db_cnt_nx;
  logic [CW-1:0] hold_cnt, hold_cnt_nx;
  logic [CW-1:0] rep_cnt, rep_cnt_nx;
  logic          press_nx, release_nx, long_nx, repeat_nx;
  logic          held;

  assign held = (state == HELD) || (state == RELEASE_DB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nx;
      db_cnt        <= db_cnt_nx;
      hold_cnt      <= hold_cnt_nx;
      rep_cnt       <= rep_cnt_nx;
      btn_level     <= (state_nx == HELD) || (state_nx == RELEASE_DB);
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      long_pulse    <= long_nx;
      repeat_pulse  <= repeat_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    db_cnt_nx = db_cnt;
    case (state)
      IDLE: begin
        if (in_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = HELD;
          end else begin
            state_nx  = PRESS_DB;
            db_cnt_nx = ONE;
          end
        end
      end
      PRESS_DB: begin
        if (!in_sync) begin
          state_nx  = IDLE;
          db_cnt_nx = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nx  = HELD;
          db_cnt_nx = '0;
        end else begin
          db_cnt_nx = db_cnt + ONE;
        end
      end
      HELD: begin
        if (!in_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = IDLE;
          end else begin
            state_nx  = RELEASE_DB;
            db_cnt_nx = ONE;
          end
        end
      end
      RELEASE_DB: begin
        if (in_sync) begin
          state_nx  = HELD;
          db_cnt_nx = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nx  = IDLE;
          db_cnt_nx = '0;
        end else begin
          db_cnt_nx = db_cnt + ONE;
        end
      end
      default: begin
        state_nx  = IDLE;
        db_cnt_nx = '0;
      end
    endcase
  end

  // Hold timing advances only on high samples, so a release bounce delays long/repeat
  // by exactly its length; hold_cnt saturates at HOLD_CYCLES and rep_cnt takes over.
  always_comb begin
    press_nx    = 1'b0;
    release_nx  = 1'b0;
    long_nx     = 1'b0;
    repeat_nx   = 1'b0;
    hold_cnt_nx = hold_cnt;
    rep_cnt_nx  = rep_cnt;
    press_nx    = !held && (state_nx == HELD);
    release_nx  = held && (state_nx == IDLE);
    if (press_nx || release_nx) begin
      hold_cnt_nx = '0;
      rep_cnt_nx  = '0;
    end else if (held && in_sync) begin
      if (hold_cnt != HOLD_MAX) begin
        hold_cnt_nx = hold_cnt + ONE;
        long_nx     = (hold_cnt == HOLD_LAST);
      end else if (REPEAT_EN) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt_nx = '0;
          repeat_nx  = 1'b1;
        end else begin
          rep_cnt_nx = rep_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed scenarios plus random bounce against a sample-count model
// Instance a has auto-repeat enabled, instance b has it disabled; both share stimulus.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_sync = 1'b0;
  logic lvl_a, press_a, rel_a, long_a, rep_a;
  logic lvl_b, press_b, rel_b, long_b, rep_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // model state: pressed flag, run of samples opposing it, high samples since press
  bit m_pressed [2];
  int m_run [2];
  int m_hi [2];
  bit ex_lvl [2], ex_press [2], ex_rel [2], ex_long [2], ex_rep [2];

  int lg_press_n, lg_press_c, lg_rel_n, lg_rel_c, lg_long_n, lg_long_c, lg_rep_n;
  int lg_long_b_n, lg_long_b_c, lg_rep_b_n;
  int rep_q [$];

  int t0, t1, tf, p;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_sync(in_sync), .btn_level(lvl_a), .press_pulse(press_a),
    .release_pulse(rel_a), .long_pulse(long_a), .repeat_pulse(rep_a)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_sync(in_sync), .btn_level(lvl_b), .press_pulse(press_b),
    .release_pulse(rel_b), .long_pulse(long_b), .repeat_pulse(rep_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset(int i);
    m_pressed[i] = 0; m_run[i] = 0; m_hi[i] = 0;
    ex_lvl[i] = 0; ex_press[i] = 0; ex_rel[i] = 0; ex_long[i] = 0; ex_rep[i] = 0;
  endfunction

  function automatic void model_step(int i, bit s, bit rep_en);
    ex_press[i] = 0; ex_rel[i] = 0; ex_long[i] = 0; ex_rep[i] = 0;
    if (!m_pressed[i]) begin
      m_run[i] = s ? m_run[i] + 1 : 0;
      if (m_run[i] == D) begin
        m_pressed[i] = 1; m_run[i] = 0; m_hi[i] = 0; ex_press[i] = 1;
      end
    end else if (!s) begin
      m_run[i]++;
      if (m_run[i] == D) begin
        m_pressed[i] = 0; m_run[i] = 0; ex_rel[i] = 1;
      end
    end else begin
      m_run[i] = 0;
      m_hi[i]++;
      if (m_hi[i] == H) ex_long[i] = 1;
      else if (rep_en && m_hi[i] > H && (m_hi[i] - H) % R == 0) ex_rep[i] = 1;
    end
    ex_lvl[i] = m_pressed[i];
  endfunction

  task automatic clear_log();
    lg_press_n = 0; lg_press_c = -1; lg_rel_n = 0; lg_rel_c = -1;
    lg_long_n = 0; lg_long_c = -1; lg_rep_n = 0;
    lg_long_b_n = 0; lg_long_b_c = -1; lg_rep_b_n = 0;
    rep_q.delete();
  endtask

  task automatic cmp_inst(input int e, input string tag, input logic [4:0] act, input logic [4:0] exp);
    string fn [5];
    fn = '{"lvl", "press", "release", "long", "repeat"};
    for (int j = 0; j < 5; j++)
      chk($sformatf("cyc%0d.%s.%s", e, tag, fn[j]), 32'(act[4-j]), 32'(exp[4-j]));
  endtask

  always begin
    int e;
    bit s;
    @(posedge clk);
    s = in_sync;
    e = cyc;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst) model_reset(i);
      else model_step(i, s, i == 0);
    end
    if (ex_press[0]) begin lg_press_n++; lg_press_c = e; end
    if (ex_rel[0]) begin lg_rel_n++; lg_rel_c = e; end
    if (ex_long[0]) begin lg_long_n++; lg_long_c = e; end
    if (ex_rep[0]) begin lg_rep_n++; rep_q.push_back(e); end
    if (ex_long[1]) begin lg_long_b_n++; lg_long_b_c = e; end
    if (ex_rep[1]) lg_rep_b_n++;
    #1;
    cmp_inst(e, "a", {lvl_a, press_a, rel_a, long_a, rep_a},
             {ex_lvl[0], ex_press[0], ex_rel[0], ex_long[0], ex_rep[0]});
    cmp_inst(e, "b", {lvl_b, press_b, rel_b, long_b, rep_b},
             {ex_lvl[1], ex_press[1], ex_rel[1], ex_long[1], ex_rep[1]});
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      in_sync = v;
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".a"}, 32'({lvl_a, press_a, rel_a, long_a, rep_a}), 32'd0);
    chk({nm, ".b"}, 32'({lvl_b, press_b, rel_b, long_b, rep_b}), 32'd0);
  endtask

  initial begin
    clear_log();
    #1;
    chk_all_zero("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: async reset while pressed, then release with the button up
    drive(1, 8);
    chk("pre_rst.lvl_a", 32'(lvl_a), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    in_sync = 1'b0;
    #1;
    chk_all_zero("rst_async");
    drive(1, 1);
    drive(0, 1);
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    drive(0, 6);
    chk("rst_idle.press_n", 32'(lg_press_n), 32'd0);
    chk("rst_idle.rel_n", 32'(lg_rel_n), 32'd0);

    // 2: bounce rejection
    clear_log();
    drive(1, 3); drive(0, 1); drive(1, 3); drive(0, 6);
    chk("bounce.press_n", 32'(lg_press_n), 32'd0);

    // 3: clean 20-cycle press
    clear_log();
    @(negedge clk); in_sync = 1'b1; t0 = cyc;
    drive(1, 19);
    drive(0, 8);
    p = t0 + 3;
    chk("clean.press_c", 32'(lg_press_c), 32'(p));
    chk("clean.long_c", 32'(lg_long_c), 32'(p + 10));
    chk("clean.rep_n", 32'(lg_rep_n), 32'd2);
    if (rep_q.size() == 2) begin
      chk("clean.rep0", 32'(rep_q[0]), 32'(p + 13));
      chk("clean.rep1", 32'(rep_q[1]), 32'(p + 16));
    end
    chk("clean.rel_c", 32'(lg_rel_c), 32'(t0 + 23));
    chk("clean.press_n", 32'(lg_press_n), 32'd1);
    chk("clean.rel_n", 32'(lg_rel_n), 32'd1);

    // 4: release glitch before the long threshold
    clear_log();
    @(negedge clk); in_sync = 1'b1; t0 = cyc;
    drive(1, 7); drive(0, 2); drive(1, 20);
    chk("glitch.rel_n", 32'(lg_rel_n), 32'd0);
    chk("glitch.long_c", 32'(lg_long_c), 32'(t0 + 3 + 12));
    @(negedge clk); in_sync = 1'b0; tf = cyc;
    drive(0, 6);
    chk("glitch.rel_c", 32'(lg_rel_c), 32'(tf + 3));

    // 5: 40-cycle hold, instance b has repeat disabled
    clear_log();
    @(negedge clk); in_sync = 1'b1; t0 = cyc;
    drive(1, 39); drive(0, 8);
    chk("norep.long_b_n", 32'(lg_long_b_n), 32'd1);
    chk("norep.long_b_c", 32'(lg_long_b_c), 32'(t0 + 13));
    chk("norep.rep_b_n", 32'(lg_rep_b_n), 32'd0);
    chk("norep.rep_a_n", 32'(lg_rep_n), 32'd8);

    // 6: reset in cycle P+5 while held, released with button still down
    clear_log();
    @(negedge clk); in_sync = 1'b1; t0 = cyc;
    for (int k = 0; k < 40 && cyc != t0 + 9; k++) @(negedge clk);
    chk("rsth.reached", 32'(cyc), 32'(t0 + 9));
    rst = 1'b0;
    #1;
    chk_all_zero("rsth_async");
    repeat (2) @(negedge clk);
    rst = 1'b1; t1 = cyc;
    drive(1, 18);
    chk("rsth.rel_n", 32'(lg_rel_n), 32'd0);
    chk("rsth.press_n", 32'(lg_press_n), 32'd2);
    chk("rsth.press_c", 32'(lg_press_c), 32'(t1 + 3));
    chk("rsth.long_c", 32'(lg_long_c), 32'(t1 + 13));
    drive(0, 6);

    // random bouncing runs with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk); rst = 1'b0;
        drive(1'($urandom_range(0, 1)), $urandom_range(1, 2));
        @(negedge clk); rst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) drive(1'(n & 1), $urandom_range(8, 30));
      else drive(1'(n & 1), $urandom_range(1, 6));
    end
    drive(0, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
